ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Consumer end of the collision path: takes registered paddle collision flags and owns the ball's position and velocity.
- Once per frame it steps the ball, reflects it off the top/bottom walls and off the paddles, and detects misses.
- Drives the ball rectangle back into the collision checkers and into the renderer.
- Drives one-cycle score pulses to the score keeper.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- SPEED_X, 2, horizontal step per frame
- SPEED_Y, 2, vertical step per frame
- COOLDOWN_FRAMES, 4, frames during which further paddle hits are ignored after a bounce
- SCORE_HOLD_FRAMES, 60, frames the ball stays frozen after a miss

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- frame_tick_i  in  1  one-cycle pulse per frame, at end of active video
- serve_i  in  1  level; serve request while idle
- paddle_l_hit_i  in  1  ball/left-paddle collision flag
- paddle_r_hit_i  in  1  ball/right-paddle collision flag
- ball_left  out  X_POS_W  ball x (inclusive)
- ball_right  out  X_POS_W  ball_left + BALL_SIZE (exclusive)
- ball_top  out  Y_POS_W  ball y (inclusive)
- ball_bottom  out  Y_POS_W  ball_top + BALL_SIZE (exclusive)
- score_l_o  out  1  one-cycle pulse; left player scored (ball exited right)
- score_r_o  out  1  one-cycle pulse; right player scored (ball exited left)
- moving_o  out  1  high in MOVE state

Widths X_POS_W and Y_POS_W come from config.svh.

Behaviour:
- Reset, one cycle, synchronous, active-high:
  - x = (SCREEN_W-BALL_SIZE)/2 = 316; y = (SCREEN_H-BALL_SIZE)/2 = 236
  - dir_x = right, dir_y = down
  - state IDLE; cooldown 0; hit latches 0; hold counter 0
  - score pulses 0; moving_o 0
- Reset is honoured in any state, including mid-frame.
- All outputs are registered and update the cycle after the frame_tick_i that causes the change.
- Hit latches:
  - hit_l_q / hit_r_q are set by the paddle inputs on any cycle.
  - At frame_tick_i the effective hit is latch OR current input; the latch is then cleared.
  - This absorbs the 1-cycle latency of the collision checker.
- States: IDLE, MOVE, SCORED. Only frame_tick_i cycles advance the state.
- IDLE:
  - Ball held at centre.
  - frame_tick_i && serve_i -> MOVE. Position is unchanged on that tick.
- MOVE, evaluated in this order on each tick:
  1. If cooldown != 0, decrement it.
  2. Paddle bounce:
     - Effective hit_l with dir_x == left and cooldown == 0 (pre-decrement) -> dir_x = right, cooldown = COOLDOWN_FRAMES.
     - Mirror rule for hit_r with dir_x == right.
     - A hit on the paddle the ball is moving away from is ignored.
     - If both hits are asserted, only the one matching dir_x acts.
  3. Vertical:
     - Down and y + SPEED_Y >= SCREEN_H - BALL_SIZE -> y = SCREEN_H - BALL_SIZE, dir_y = up.
     - Up and y <= SPEED_Y -> y = 0, dir_y = down.
     - Otherwise y steps by SPEED_Y.
  4. Horizontal, using the updated dir_x:
     - Right and x + SPEED_X >= SCREEN_W - BALL_SIZE -> x = SCREEN_W - BALL_SIZE, pulse score_l_o, go to SCORED.
     - Left and x <= SPEED_X -> x = 0, pulse score_r_o, go to SCORED.
     - Otherwise x steps by SPEED_X.
- SCORED:
  - Position frozen; hits ignored and latches cleared.
  - Hold counter counts frame ticks.
  - On the SCORE_HOLD_FRAMES-th tick: ball to centre, dir_x pointed toward the player who conceded, dir_y = down, state IDLE.
- Arithmetic: sums are computed one bit wider than the position width, so there is no wrap-around. Positions never leave [0, SCREEN-BALL_SIZE].
- Score pulses are exactly one clk_i cycle and never assert outside a MOVE->SCORED transition.

Decomposition:
- pong_pkg:
  - ball_state_t enum {IDLE, MOVE, SCORED}
  - dir_t (1-bit: LEFT/RIGHT, UP/DOWN)
  - Centre-position constants, derived from the parameters via functions
- Optional sub-module ball_axis_step: one axis's step, bounds clamp, and reflect flag. Instantiated twice, with the score/exit outputs used only on X.

Test Plan:
- Reset -> ball_left 316, ball_right 324, ball_top 236, ball_bottom 244, moving_o 0. 10 ticks without serve_i -> unchanged.
- serve_i high over tick 1 -> moving_o 1, position unchanged. Tick 2 -> ball_left 318, ball_top 238.
- Free run, no hits: on the 118th MOVE tick ball_top 472 and dir flips. Next tick ball_top 470, ball_left 554.
- Right exit: with no hits, the 158th MOVE tick gives ball_left 632 and score_l_o high for exactly 1 cycle. After 60 more ticks: centre, IDLE, next serve moves right.
- Paddle bounce:
  - paddle_r_hit_i pulsed mid-frame while moving right -> next tick ball_left decreases by 2.
  - Pulse again 1 frame later -> ignored (cooldown).
  - paddle_l_hit_i while moving right -> ignored.
- Reset asserted mid-MOVE with hit latch set -> next cycle centre, IDLE, latches 0, no score pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the ball datapath.
//   ball_state_t : ball controller state (IDLE, MOVE, SCORED)
//   dir_x_t      : horizontal direction (LEFT / RIGHT)
//   dir_y_t      : vertical direction (UP / DOWN)
//   X_POS_W/Y_POS_W : position widths for the 640x480 playfield
//   centre_pos() : centred top-left coordinate of the ball on one axis
package pong_pkg;

    // Position widths: 10 bits covers x in [0,640], 9 bits covers y in [0,480].
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_x_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_y_t;

    function automatic int centre_pos(input int screen, input int size);
        return (screen - size) / 2;
    endfunction

endpackage

// File: rtl/ball_motion_axis_step.sv
// ball_axis_step: one axis of the per-frame ball step.
//   pos_i  : current position
//   inc_i  : 1 = moving toward LIMIT, 0 = moving toward 0
//   pos_o  : next position, clamped to [0, LIMIT]
//   edge_o : the step reached a bound (reflect on Y, exit on X)
module ball_axis_step #(
    parameter int POS_W = 10,
    parameter int LIMIT = 632,
    parameter int SPEED = 2
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic             inc_i,
    output logic [POS_W-1:0] pos_o,
    output logic             edge_o
);

    localparam logic [POS_W:0] LIMIT_W = (POS_W+1)'(LIMIT);
    localparam logic [POS_W:0] SPEED_W = (POS_W+1)'(SPEED);

    logic [POS_W:0] pos_w;
    logic [POS_W:0] sum_w;

    // One extra bit so the increment cannot wrap before the bound compare.
    always_comb begin
        pos_w  = {1'b0, pos_i};
        sum_w  = pos_w + SPEED_W;
        pos_o  = pos_i;
        edge_o = 1'b0;
        if (inc_i) begin
            if (sum_w >= LIMIT_W) begin
                pos_o  = LIMIT_W[POS_W-1:0];
                edge_o = 1'b1;
            end else begin
                pos_o = sum_w[POS_W-1:0];
            end
        end else begin
            if (pos_w <= SPEED_W) begin
                pos_o  = '0;
                edge_o = 1'b1;
            end else begin
                pos_o = pos_i - SPEED_W[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: owns the ball position/velocity, steps it once per frame,
// bounces it off walls and paddles, and reports misses as score pulses.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   frame_tick_i          : one-cycle pulse per frame
//   serve_i               : serve request (level) while idle
//   paddle_l/r_hit_i      : collision flags from the paddle checkers
//   ball_left/right/top/bottom : ball rectangle (right/bottom exclusive)
//   score_l_o / score_r_o : one-cycle pulse, left / right player scored
//   moving_o              : ball is in play
module ball_motion
    import pong_pkg::*;
#(
    parameter int SCREEN_W          = 640,
    parameter int SCREEN_H          = 480,
    parameter int BALL_SIZE         = 8,
    parameter int SPEED_X           = 2,
    parameter int SPEED_Y           = 2,
    parameter int COOLDOWN_FRAMES   = 4,
    parameter int SCORE_HOLD_FRAMES = 60
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic               serve_i,
    input  logic               paddle_l_hit_i,
    input  logic               paddle_r_hit_i,
    output logic [X_POS_W-1:0] ball_left,
    output logic [X_POS_W-1:0] ball_right,
    output logic [Y_POS_W-1:0] ball_top,
    output logic [Y_POS_W-1:0] ball_bottom,
    output logic               score_l_o,
    output logic               score_r_o,
    output logic               moving_o
);

    localparam logic [X_POS_W-1:0] X_CENTRE = X_POS_W'(centre_pos(SCREEN_W, BALL_SIZE));
    localparam logic [Y_POS_W-1:0] Y_CENTRE = Y_POS_W'(centre_pos(SCREEN_H, BALL_SIZE));
    localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam int HOLD_W = $clog2(SCORE_HOLD_FRAMES + 1);
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD_FRAMES - 1);

    ball_state_t        state_q, state_d;
    logic [X_POS_W-1:0] x_q, x_d;
    logic [Y_POS_W-1:0] y_q, y_d;
    dir_x_t             dir_x_q, dir_x_d;
    dir_y_t             dir_y_q, dir_y_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               hit_l_q, hit_l_d, hit_r_q, hit_r_d;
    logic               score_l_q, score_l_d, score_r_q, score_r_d;
    logic               moving_q, moving_d;

    logic               hit_l_eff, hit_r_eff, bounce;
    dir_x_t             dir_x_mv;
    logic [X_POS_W-1:0] x_nxt;
    logic [Y_POS_W-1:0] y_nxt;
    logic               x_edge, y_edge;

    // Latch OR live input covers a hit the checker reports on the tick cycle.
    // Only the paddle the ball is heading toward can reflect it.
    always_comb begin
        hit_l_eff = hit_l_q | paddle_l_hit_i;
        hit_r_eff = hit_r_q | paddle_r_hit_i;
        dir_x_mv  = dir_x_q;
        bounce    = 1'b0;
        if (cool_q == '0) begin
            if (hit_l_eff && dir_x_q == DIR_LEFT) begin
                dir_x_mv = DIR_RIGHT;
                bounce   = 1'b1;
            end else if (hit_r_eff && dir_x_q == DIR_RIGHT) begin
                dir_x_mv = DIR_LEFT;
                bounce   = 1'b1;
            end
        end
    end

    ball_axis_step #(
        .POS_W (X_POS_W),
        .LIMIT (SCREEN_W - BALL_SIZE),
        .SPEED (SPEED_X)
    ) u_x_step (
        .pos_i  (x_q),
        .inc_i  (dir_x_mv == DIR_RIGHT),
        .pos_o  (x_nxt),
        .edge_o (x_edge)
    );

    ball_axis_step #(
        .POS_W (Y_POS_W),
        .LIMIT (SCREEN_H - BALL_SIZE),
        .SPEED (SPEED_Y)
    ) u_y_step (
        .pos_i  (y_q),
        .inc_i  (dir_y_q == DIR_DOWN),
        .pos_o  (y_nxt),
        .edge_o (y_edge)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cool_d    = cool_q;
        hold_d    = hold_q;
        hit_l_d   = hit_l_eff;
        hit_r_d   = hit_r_eff;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = X_CENTRE;
                y_d = Y_CENTRE;
                if (frame_tick_i) begin
                    hit_l_d = 1'b0;
                    hit_r_d = 1'b0;
                    if (serve_i) state_d = MOVE;
                end
            end
            MOVE: begin
                if (frame_tick_i) begin
                    hit_l_d = 1'b0;
                    hit_r_d = 1'b0;
                    if (cool_q != '0) cool_d = cool_q - 1'b1;
                    if (bounce) cool_d = COOL_INIT;
                    dir_x_d = dir_x_mv;
                    y_d     = y_nxt;
                    if (y_edge) dir_y_d = (dir_y_q == DIR_DOWN) ? DIR_UP : DIR_DOWN;
                    x_d = x_nxt;
                    if (x_edge) begin
                        if (dir_x_mv == DIR_RIGHT) score_l_d = 1'b1;
                        else                       score_r_d = 1'b1;
                        state_d = SCORED;
                        hold_d  = '0;
                    end
                end
            end
            SCORED: begin
                hit_l_d = 1'b0;
                hit_r_d = 1'b0;
                if (frame_tick_i) begin
                    if (hold_q == HOLD_LAST) begin
                        // dir_x still points at the side that conceded: serve there.
                        state_d = IDLE;
                        hold_d  = '0;
                        cool_d  = '0;
                        x_d     = X_CENTRE;
                        y_d     = Y_CENTRE;
                        dir_y_d = DIR_DOWN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        moving_d = (state_d == MOVE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            dir_x_q   <= DIR_RIGHT;
            dir_y_q   <= DIR_DOWN;
            cool_q    <= '0;
            hold_q    <= '0;
            hit_l_q   <= 1'b0;
            hit_r_q   <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            moving_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cool_q    <= cool_d;
            hold_q    <= hold_d;
            hit_l_q   <= hit_l_d;
            hit_r_q   <= hit_r_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            moving_q  <= moving_d;
        end
    end

    assign ball_left   = x_q;
    assign ball_right  = x_q + X_POS_W'(BALL_SIZE);
    assign ball_top    = y_q;
    assign ball_bottom = y_q + Y_POS_W'(BALL_SIZE);
    assign score_l_o   = score_l_q;
    assign score_r_o   = score_r_q;
    assign moving_o    = moving_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a queue-based scoreboard of expected
// ball rectangle / status values.
module tb_ball_motion;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic rst, frame_tick, serve, pad_l, pad_r;
    logic [X_POS_W-1:0] ball_left, ball_right;
    logic [Y_POS_W-1:0] ball_top, ball_bottom;
    logic score_l, score_r, moving;

    ball_motion dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_tick_i   (frame_tick),
        .serve_i        (serve),
        .paddle_l_hit_i (pad_l),
        .paddle_r_hit_i (pad_r),
        .ball_left      (ball_left),
        .ball_right     (ball_right),
        .ball_top       (ball_top),
        .ball_bottom    (ball_bottom),
        .score_l_o      (score_l),
        .score_r_o      (score_r),
        .moving_o       (moving)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string tag;
        int    left;
        int    top;
        bit    mv;
        bit    sl;
        bit    sr;
    } exp_t;

    exp_t sb[$];

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input int l, input int t,
                        input bit mv, input bit sl, input bit sr);
        exp_t e;
        e.tag = tag; e.left = l; e.top = t; e.mv = mv; e.sl = sl; e.sr = sr;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".left"},    32'(ball_left),   32'(e.left));
        cmp({e.tag, ".right"},   32'(ball_right),  32'(e.left + 8));
        cmp({e.tag, ".top"},     32'(ball_top),    32'(e.top));
        cmp({e.tag, ".bottom"},  32'(ball_bottom), 32'(e.top + 8));
        cmp({e.tag, ".moving"},  32'(moving),      32'(e.mv));
        cmp({e.tag, ".score_l"}, 32'(score_l),     32'(e.sl));
        cmp({e.tag, ".score_r"}, 32'(score_r),     32'(e.sr));
    endtask

    // Expected state right now (sampled at the falling edge).
    task automatic expect_now(input string tag, input int l, input int t,
                              input bit mv, input bit sl, input bit sr);
        push(tag, l, t, mv, sl, sr);
        pop_check();
    endtask

    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse(input bit l, input bit r);
        @(negedge clk) begin pad_l = l; pad_r = r; end
        @(negedge clk) begin pad_l = 1'b0; pad_r = 1'b0; end
    endtask

    task automatic serve_tick();
        serve = 1'b1;
        do_tick();
        serve = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; serve = 1'b0; pad_l = 1'b0; pad_r = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_now("reset", 316, 236, 0, 0, 0);

        // Idle without serve: ball stays at centre.
        repeat (10) do_tick();
        expect_now("idle_10", 316, 236, 0, 0, 0);

        // Serve tick enters MOVE without moving the ball.
        serve_tick();
        expect_now("serve", 316, 236, 1, 0, 0);
        do_tick();
        expect_now("move_1", 318, 238, 1, 0, 0);

        // Bottom wall on MOVE tick 118.
        repeat (117) do_tick();
        expect_now("move_118", 552, 472, 1, 0, 0);
        do_tick();
        expect_now("move_119", 554, 470, 1, 0, 0);

        // Right exit on MOVE tick 158: y = 472 - 2*40.
        repeat (38) do_tick();
        expect_now("move_157", 630, 394, 1, 0, 0);
        do_tick();
        expect_now("exit_right", 632, 392, 0, 1, 0);
        @(negedge clk);
        expect_now("score_pulse_end", 632, 392, 0, 0, 0);

        // Frozen for 59 ticks, centred on the 60th.
        repeat (59) do_tick();
        expect_now("hold_59", 632, 392, 0, 0, 0);
        do_tick();
        expect_now("hold_60", 316, 236, 0, 0, 0);

        // Re-serve heads right (toward the conceding player).
        serve_tick();
        expect_now("reserve", 316, 236, 1, 0, 0);
        do_tick();
        expect_now("reserve_1", 318, 238, 1, 0, 0);

        // Right paddle hit mid-frame reverses x.
        pulse(1'b0, 1'b1);
        do_tick();
        expect_now("bounce_r", 316, 240, 1, 0, 0);
        pulse(1'b0, 1'b1);
        do_tick();
        expect_now("r_again_ignored", 314, 242, 1, 0, 0);
        pulse(1'b1, 1'b0);
        do_tick();
        expect_now("l_cooldown_ignored", 312, 244, 1, 0, 0);
        repeat (2) do_tick();
        expect_now("cooldown_run", 308, 248, 1, 0, 0);
        // Cooldown expired: left paddle now bounces.
        pulse(1'b1, 1'b0);
        do_tick();
        expect_now("bounce_l", 310, 250, 1, 0, 0);
        // Left paddle while heading right is ignored.
        pulse(1'b1, 1'b0);
        do_tick();
        expect_now("l_away_ignored", 312, 252, 1, 0, 0);
        repeat (3) do_tick();
        expect_now("free_run", 318, 258, 1, 0, 0);

        // Mid-MOVE reset with a pending right-hit latch.
        pulse(1'b0, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        expect_now("mid_reset", 316, 236, 0, 0, 0);
        serve_tick();
        expect_now("post_reset_serve", 316, 236, 1, 0, 0);
        do_tick();
        expect_now("latch_cleared", 318, 238, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
